uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter BAUD_SEL, default 3'd4: baud code driven to the transmitter.
REQ-003 Parameter TIMEOUT_CYC, default 200000: maximum clk cycles to wait for tx_done after launch.
REQ-004 clk  in  1  single system clock (20 MHz PLL output); all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  N_REQ  per-requester level request; held until matching req_ack.
REQ-007 req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i] high.
REQ-008 req_ack  out  N_REQ  one-cycle pulse: requester's byte fully transmitted.
REQ-009 tx_send_en  out  1  one-cycle launch pulse to the transmitter.
REQ-010 tx_data_byte  out  8  byte to the transmitter.
REQ-011 tx_baud_set  out  3  constant BAUD_SEL.
REQ-012 tx_done  in  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-013 tx_busy  in  1  transmitter uart_state; high while shifting.
REQ-014 grant_id  out  3  index of the current or last granted requester.
REQ-015 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 FSM states IDLE, GRANT, SEND, WAIT; all outputs registered.
REQ-017 IDLE: if any req bit is high and tx_busy is low, the block selects the winner and moves to GRANT; otherwise it stays in IDLE.
REQ-018 Round-robin: search starts at (last_grant+1) mod N_REQ; after reset last_grant = N_REQ-1, so requester 0 has first priority.
REQ-019 GRANT: latch the winner's req_data into tx_data_byte, update grant_id, go to SEND.
REQ-020 SEND: drive tx_send_en high for exactly this one cycle, clear the watchdog, go to WAIT.
REQ-021 Latency: req sampled high in IDLE at edge N gives tx_send_en high in the cycle following edge N+2.
REQ-022 WAIT: on tx_done, pulse req_ack[grant_id] in the next cycle, update last_grant, return to IDLE.
REQ-023 tx_data_byte holds its value from GRANT until the next GRANT; it does not change while in WAIT.
REQ-024 Withdrawal: req dropped before grant has no effect; req dropped after GRANT does not abort the transfer, and req_ack still pulses.
REQ-025 Watchdog: a counter of width ceil(log2(TIMEOUT_CYC)) increments in WAIT. If it reaches TIMEOUT_CYC-1 without tx_done: pulse timeout_err, give no req_ack, update last_grant, return to IDLE.
REQ-026 If tx_done and watchdog expiry fall in the same cycle, tx_done wins: ack is given and no error is raised.
REQ-027 A tx_done pulse seen outside WAIT is ignored.
REQ-028 Requests arriving during GRANT/SEND/WAIT are arbitrated only on return to IDLE; at most one req_ack bit is high in any cycle.
REQ-029 No back-to-back launch: at least one IDLE cycle separates the WAIT exit and the next GRANT.

Reset
REQ-030 rst low forces, asynchronously: state IDLE, last_grant N_REQ-1, grant_id 0, tx_data_byte 8'h00, tx_send_en 0, req_ack 0, timeout_err 0, watchdog 0.
REQ-031 Reset mid-transfer abandons the grant without an ack; after release, arbitration restarts from requester 0.
REQ-032 tx_baud_set equals BAUD_SEL at all times, including during reset.

Structure
REQ-033 Shared package uart_pkg holds the FSM state encoding, the baud code constants (3'd0..3'd4), and the default TIMEOUT_CYC.
REQ-034 The round-robin selector is a separate combinational sub-module rr_pick (inputs: req, last_grant; outputs: valid, idx).
REQ-035 The UART transmitter is instantiated by the parent, not inside this block.

Verification
REQ-036 Single request: req=4'b0001, byte 8'hA5 -> tx_send_en 2 cycles later with tx_data_byte=8'hA5; after the modelled tx_done, req_ack=4'b0001 for 1 cycle.
REQ-037 All requesters: req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> bytes launch in order 10,21,32,43,10; grant_id runs 0,1,2,3,0.
REQ-038 Watchdog: TIMEOUT_CYC=50 and tx_done never sent -> timeout_err pulses in the 50th WAIT cycle, no req_ack, next grant goes to the next requester.
REQ-039 Collision: tx_done and watchdog expiry in the same cycle -> req_ack pulses and timeout_err stays 0.
REQ-040 Reset mid-WAIT: rst low for 3 cycles -> all outputs go to reset values immediately, no ack; with req=4'b0100 after release, grant_id=2.
REQ-041 Busy guard: tx_busy high in IDLE with req=4'b0010 -> no GRANT until tx_busy falls; send_en follows 2 cycles after that.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, baud codes and watchdog default for the UART TX arbiter
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SEND, ST_WAIT} arb_state_t;
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam int TIMEOUT_DEFAULT = 200000;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: round-robin selector, the first set request after last_grant wins
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic             valid,
  output logic [2:0]       idx
);
  // scan from farthest to nearest so the nearest request after last_grant is written last
  always_comb begin
    valid = 1'b0;
    idx = 3'd0;
    for (int k = N_REQ; k > 0; k--) begin
      if (((req >> ((int'(last_grant) + k) % N_REQ)) & N_REQ'(1)) != '0) begin
        valid = 1'b1;
        idx = 3'((int'(last_grant) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte requesters
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int          N_REQ       = 4,
  parameter logic [2:0]  BAUD_SEL    = BAUD_115200,
  parameter int          TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic               tx_send_en,
  output logic [7:0]         tx_data_byte,
  output logic [2:0]         tx_baud_set,
  input  logic               tx_done,
  input  logic               tx_busy,
  output logic [2:0]         grant_id,
  output logic               timeout_err
);
  localparam int WW = $clog2(TIMEOUT_CYC);
  arb_state_t state, state_n;
  logic [2:0] win, win_n, last_grant, last_grant_n, grant_id_n;
  logic [7:0] byte_n;
  logic send_n, err_n;
  logic [N_REQ-1:0] ack_n;
  logic [WW-1:0] wdog, wdog_n;
  logic pick_valid;
  logic [2:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .last_grant(last_grant),
    .valid(pick_valid),
    .idx(pick_idx)
  );

  assign tx_baud_set = BAUD_SEL;

  // next state and next values of every registered output; tx_done wins over watchdog expiry
  always_comb begin
    state_n = state;
    win_n = win;
    last_grant_n = last_grant;
    grant_id_n = grant_id;
    byte_n = tx_data_byte;
    send_n = 1'b0;
    ack_n = '0;
    err_n = 1'b0;
    wdog_n = wdog;
    case (state)
      ST_IDLE: if (pick_valid && !tx_busy) begin
        state_n = ST_GRANT;
        win_n = pick_idx;
      end
      ST_GRANT: begin
        byte_n = req_data[8*win +: 8];
        grant_id_n = win;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        send_n = 1'b1;
        wdog_n = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          ack_n = N_REQ'(1) << grant_id;
          last_grant_n = grant_id;
          state_n = ST_IDLE;
        end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
          err_n = 1'b1;
          last_grant_n = grant_id;
          state_n = ST_IDLE;
        end else wdog_n = wdog + WW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously so a reset drops any grant in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      win <= 3'd0;
      last_grant <= 3'(N_REQ - 1);
      grant_id <= 3'd0;
      tx_data_byte <= 8'h00;
      tx_send_en <= 1'b0;
      req_ack <= '0;
      timeout_err <= 1'b0;
      wdog <= '0;
    end else begin
      state <= state_n;
      win <= win_n;
      last_grant <= last_grant_n;
      grant_id <= grant_id_n;
      tx_data_byte <= byte_n;
      tx_send_en <= send_n;
      req_ack <= ack_n;
      timeout_err <= err_n;
      wdog <= wdog_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int T = 50;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0] req, req_ack;
  logic [8*NR-1:0] req_data;
  logic tx_send_en, tx_done, tx_busy, timeout_err;
  logic tx_shift, hold_busy;
  logic [7:0] tx_data_byte;
  logic [2:0] tx_baud_set, grant_id;
  int n_chk = 0;
  int n_fail = 0;
  int fix_len = 5;
  int tx_left = 0;
  bit force_mute = 0, rand_mute = 0, spur = 0, mute_cur = 0;
  bit m_act = 0;
  int m_t = 0, m_w = 0, m_lg = NR - 1;
  logic [2:0] e_gid = '0;
  logic [7:0] e_byte = '0;
  logic e_send = 0, e_err = 0;
  logic [NR-1:0] e_ack = '0;

  always #5 clk = ~clk;
  assign tx_busy = tx_shift | hold_busy;

  uart_tx_arbiter #(.N_REQ(NR), .BAUD_SEL(3'd4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .tx_send_en(tx_send_en), .tx_data_byte(tx_data_byte), .tx_baud_set(tx_baud_set),
    .tx_done(tx_done), .tx_busy(tx_busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr(input logic [NR-1:0] r, input int lg);
    for (int k = 1; k <= NR; k++) if (r[(lg + k) % NR]) return (lg + k) % NR;
    return 0;
  endfunction

  function automatic logic hit(input int sel);
    return sel == 0 ? tx_send_en : sel == 1 ? |req_ack : timeout_err;
  endfunction

  task automatic wait_for(input int sel, input string nm, output int n);
    n = 0;
    while (!hit(sel) && n < 400) begin
      tick();
      n++;
    end
    chk(nm, 32'(hit(sel)), 1);
  endtask

  // transaction-level model: a grant decided at edge e launches after e+2, then up to T wait cycles
  always @(posedge clk) begin
    e_send = 0;
    e_ack = '0;
    e_err = 0;
    if (!rst) begin
      m_act = 0;
      m_lg = NR - 1;
      e_gid = '0;
      e_byte = '0;
    end else if (!m_act) begin
      if (req != '0 && !tx_busy) begin
        m_w = rr(req, m_lg);
        m_act = 1;
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == 1) begin
        e_gid = 3'(m_w);
        e_byte = req_data[8*m_w +: 8];
      end else if (m_t == 2) e_send = 1;
      else if (tx_done) begin
        e_ack[m_w] = 1'b1;
        m_lg = m_w;
        m_act = 0;
      end else if (m_t - 2 == T) begin
        e_err = 1;
        m_lg = m_w;
        m_act = 0;
      end
    end
  end

  // cycle compare of every output against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_grant_id", grant_id, 0);
      chk("rst_byte", tx_data_byte, 0);
      chk("rst_send_en", tx_send_en, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      chk("grant_id", grant_id, e_gid);
      chk("tx_data_byte", tx_data_byte, e_byte);
      chk("tx_send_en", tx_send_en, e_send);
      chk("req_ack", req_ack, e_ack);
      chk("timeout_err", timeout_err, e_err);
    end
    chk("tx_baud_set", tx_baud_set, 3'd4);
  end

  // transmitter stand-in: busy for fix_len (or random) cycles after a launch, then tx_done
  initial begin
    tx_shift = 0;
    tx_done = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 0;
      if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) begin
          tx_shift = 0;
          tx_done = !mute_cur;
        end
      end else if (tx_send_en) begin
        mute_cur = force_mute || (rand_mute && $urandom_range(0, 7) == 0);
        tx_left = fix_len >= 0 ? fix_len : int'($urandom_range(0, 60));
        if (tx_left == 0) tx_done = !mute_cur;
        else tx_shift = 1;
      end else if (spur && $urandom_range(0, 31) == 0) tx_done = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] eb [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int eg [5] = '{0, 1, 2, 3, 0};
    int n;
    logic seen;
    req = '0;
    req_data = '0;
    hold_busy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gid", grant_id, 0);
    chk("reset_byte", tx_data_byte, 0);
    chk("reset_baud", tx_baud_set, 3'd4);
    rst = 1;
    tick();
    // single request, launch three edges after the request is driven
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    tick(); tick(); tick();
    chk("t1_send", tx_send_en, 1);
    chk("t1_byte", tx_data_byte, 8'hA5);
    tick();
    wait_for(1, "t1_ack_seen", n);
    chk("t1_ack", req_ack, 4'b0001);
    req = '0;
    tick();
    rst = 0;
    tick();
    rst = 1;
    tick();
    // all requesters held: rotation 0,1,2,3,0
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_for(0, "t2_send_seen", n);
      chk("t2_byte", tx_data_byte, eb[j]);
      chk("t2_gid", grant_id, eg[j]);
      if (j == 4) req = '0;
      tick();
    end
    wait_for(1, "t2_ack_seen", n);
    chk("t2_ack", req_ack, 4'b0001);
    // watchdog: no tx_done, error after the 50th wait cycle, next grant moves on
    force_mute = 1;
    fix_len = 70;
    req = 4'b0110;
    wait_for(0, "t3_send_seen", n);
    chk("t3_gid", grant_id, 1);
    tick();
    wait_for(2, "t3_err_seen", n);
    chk("t3_err_dist", n + 1, 50);
    chk("t3_no_ack", req_ack, 0);
    force_mute = 0;
    fix_len = 5;
    wait_for(0, "t3_next_seen", n);
    chk("t3_next_gid", grant_id, 2);
    req = '0;
    tick();
    wait_for(1, "t3_ack_seen", n);
    chk("t3_ack", req_ack, 4'b0100);
    // tx_done in the same cycle as expiry: ack wins
    fix_len = 49;
    req_data[31:24] = 8'hC3;
    req = 4'b1000;
    wait_for(0, "t4_send_seen", n);
    chk("t4_gid", grant_id, 3);
    tick();
    wait_for(1, "t4_ack_seen", n);
    chk("t4_ack_dist", n + 1, 50);
    chk("t4_ack", req_ack, 4'b1000);
    chk("t4_no_err", timeout_err, 0);
    req = '0;
    // reset in the middle of a wait
    fix_len = 30;
    req_data[15:8] = 8'h5C;
    req = 4'b0010;
    wait_for(0, "t5_send_seen", n);
    chk("t5_gid", grant_id, 1);
    repeat (5) tick();
    rst = 0;
    req = '0;
    #1;
    chk("t5_rst_gid", grant_id, 0);
    chk("t5_rst_byte", tx_data_byte, 0);
    chk("t5_rst_ack", req_ack, 0);
    repeat (3) @(posedge clk);
    #1;
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    rst = 1;
    fix_len = 5;
    wait_for(0, "t5_next_seen", n);
    chk("t5_next_gid", grant_id, 2);
    chk("t5_next_byte", tx_data_byte, 8'h77);
    req = '0;
    tick();
    wait_for(1, "t5_ack_seen", n);
    chk("t5_ack", req_ack, 4'b0100);
    // busy guard holds arbitration in idle
    hold_busy = 1;
    req_data[15:8] = 8'hE1;
    req = 4'b0010;
    seen = 0;
    repeat (10) begin
      tick();
      seen = seen | tx_send_en;
    end
    chk("t6_blocked", seen, 0);
    hold_busy = 0;
    tick(); tick();
    chk("t6_not_early", tx_send_en, 0);
    tick();
    chk("t6_send", tx_send_en, 1);
    chk("t6_byte", tx_data_byte, 8'hE1);
    req = '0;
    tick();
    wait_for(1, "t6_ack_seen", n);
    chk("t6_ack", req_ack, 4'b0010);
    // randomized traffic with withdrawals, random lengths, timeouts and stray tx_done
    spur = 1;
    rand_mute = 1;
    fix_len = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i]) req[i] = 0;
        else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 0;
      end
    end
    req = '0;
    spur = 0;
    rand_mute = 0;
    repeat (200) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
